// File: rtl/ili9341_pkg.sv
// ILI9341 command sequencer package.
// Holds the init ROM entry format, the sequencer state type, the panel command mnemonics and
// small constructors used to build ROM entries.
package ili9341_pkg;

    // ROM entry opcode: CMD/DATA select the D/C level, DELAY waits val ms, END hands over to host.
    typedef enum logic [1:0] {
        OpCmd   = 2'b00,
        OpData  = 2'b01,
        OpDelay = 2'b10,
        OpEnd   = 2'b11
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [7:0] val;
    } rom_entry_t;

    typedef enum logic [3:0] {
        StIdle,
        StHwRst,
        StHwWait,
        StFetch,
        StDecode,
        StSend,
        StWait,
        StDelay,
        StReady
    } seq_state_t;

    // Panel command opcodes (ILI9341 datasheet mnemonics).
    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;
    localparam logic [7:0] MADCTL  = 8'h36;
    localparam logic [7:0] COLMOD  = 8'h3A;

    function automatic rom_entry_t rom_cmd(input logic [7:0] v);
        return '{op: OpCmd, val: v};
    endfunction

    function automatic rom_entry_t rom_data(input logic [7:0] v);
        return '{op: OpData, val: v};
    endfunction

    function automatic rom_entry_t rom_delay(input logic [7:0] ms);
        return '{op: OpDelay, val: ms};
    endfunction

    function automatic rom_entry_t rom_end();
        return '{op: OpEnd, val: 8'h00};
    endfunction

endpackage

// File: rtl/ili9341_init_rom.sv
// ILI9341 power-up init ROM.
// Case-based ROM with a registered output (1-cycle read latency). Unused addresses read as END.
// Ports:
//   clk_i    clock
//   rst_ni   async active-low reset (output register clears to END)
//   addr_i   entry address
//   entry_o  {op, val} entry, valid one cycle after addr_i
module ili9341_init_rom
    import ili9341_pkg::*;
#(
    parameter int unsigned ROM_AW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ROM_AW-1:0] addr_i,
    output rom_entry_t        entry_o
);

    rom_entry_t entry_d, entry_q;

    always_comb begin
        entry_d = rom_end();
        case (addr_i)
            ROM_AW'(0):  entry_d = rom_cmd(SWRESET);
            ROM_AW'(1):  entry_d = rom_delay(8'd5);
            ROM_AW'(2):  entry_d = rom_cmd(SLPOUT);
            ROM_AW'(3):  entry_d = rom_delay(8'd120);   // sleep-out settle time
            ROM_AW'(4):  entry_d = rom_cmd(COLMOD);
            ROM_AW'(5):  entry_d = rom_data(8'h55);     // 16 bpp
            ROM_AW'(6):  entry_d = rom_cmd(MADCTL);
            ROM_AW'(7):  entry_d = rom_data(8'h48);     // MX + BGR
            ROM_AW'(8):  entry_d = rom_cmd(CASET);      // columns 0..239
            ROM_AW'(9):  entry_d = rom_data(8'h00);
            ROM_AW'(10): entry_d = rom_data(8'h00);
            ROM_AW'(11): entry_d = rom_data(8'h00);
            ROM_AW'(12): entry_d = rom_data(8'hEF);
            ROM_AW'(13): entry_d = rom_cmd(PASET);      // rows 0..319
            ROM_AW'(14): entry_d = rom_data(8'h00);
            ROM_AW'(15): entry_d = rom_data(8'h00);
            ROM_AW'(16): entry_d = rom_data(8'h01);
            ROM_AW'(17): entry_d = rom_data(8'h3F);
            ROM_AW'(18): entry_d = rom_delay(8'd0);     // patchable settle slot, no wait as shipped
            ROM_AW'(19): entry_d = rom_cmd(DISPON);
            default:     entry_d = rom_end();
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= rom_end();
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/ili9341_cmd_seq.sv
// ILI9341 command sequencer.
// Drives the SPI byte engine: on start it pulses the panel hardware reset, plays the init ROM
// (commands, data, ms delays) and then forwards host bytes one per valid/ready handshake.
// Owns the panel CS/DC/RESET pins.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   start_i            1-cycle pulse: begin or restart panel init
//   host_valid_i/host_dc_i/host_data_i, host_ready_o   host byte stream (dc: 0 cmd, 1 data)
//   spi_send_o, spi_data_o, spi_done_i                 byte engine handshake
//   lcd_cs_n_o, lcd_dc_o, lcd_rst_n_o                  panel pins
//   init_done_o        high in READY and while a host byte is in flight
//   busy_o             high in every state except IDLE and READY
module ili9341_cmd_seq
    import ili9341_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS  = 125000,
    parameter int unsigned RST_PULSE_MS = 10,
    parameter int unsigned RST_WAIT_MS  = 120,
    parameter int unsigned ROM_AW       = 6
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       host_valid_i,
    input  logic       host_dc_i,
    input  logic [7:0] host_data_i,
    output logic       host_ready_o,
    output logic       spi_send_o,
    output logic [7:0] spi_data_o,
    input  logic       spi_done_i,
    output logic       lcd_cs_n_o,
    output logic       lcd_dc_o,
    output logic       lcd_rst_n_o,
    output logic       init_done_o,
    output logic       busy_o
);

    localparam int unsigned DivW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLKS_PER_MS - 1);
    localparam int unsigned MsW = 16;
    localparam logic [MsW-1:0] RstPulseLast = MsW'(RST_PULSE_MS - 1);
    localparam logic [MsW-1:0] RstWaitLast  = MsW'(RST_WAIT_MS - 1);
    localparam logic [ROM_AW-1:0] AddrLast  = '1;

    seq_state_t        state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [MsW-1:0]    ms_q, ms_d;
    logic [7:0]        delay_q, delay_d;
    logic [7:0]        spi_data_q, spi_data_d;
    logic              lcd_dc_q, lcd_dc_d;
    logic              host_q, host_d;     // byte in flight came from the host
    logic              ms_tick;
    logic              tmr_clr;
    logic              advance;
    rom_entry_t        rom_q;

    ili9341_init_rom #(
        .ROM_AW (ROM_AW)
    ) u_init_rom (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .addr_i  (addr_q),
        .entry_o (rom_q)
    );

    // Free-running ms divider; cleared on entry to every timed state so each wait starts aligned.
    assign ms_tick = (div_q == DivMax);

    always_comb begin
        div_d = ms_tick ? '0 : div_q + DivW'(1);
        ms_d  = ms_tick ? ms_q + MsW'(1) : ms_q;
        if (tmr_clr) begin
            div_d = '0;
            ms_d  = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        delay_d      = delay_q;
        spi_data_d   = spi_data_q;
        lcd_dc_d     = lcd_dc_q;
        host_d       = host_q;
        tmr_clr      = 1'b0;
        advance      = 1'b0;
        spi_send_o   = 1'b0;
        lcd_cs_n_o   = 1'b1;
        lcd_rst_n_o  = 1'b1;
        host_ready_o = 1'b0;
        init_done_o  = 1'b0;
        busy_o       = 1'b1;

        case (state_q)
            StIdle: begin
                lcd_rst_n_o = 1'b0;
                busy_o      = 1'b0;
                if (start_i) begin
                    state_d = StHwRst;
                    tmr_clr = 1'b1;
                end
            end
            StHwRst: begin
                lcd_rst_n_o = 1'b0;
                if (ms_tick && ms_q == RstPulseLast) begin
                    state_d = StHwWait;
                    tmr_clr = 1'b1;
                end
            end
            StHwWait: begin
                if (ms_tick && ms_q == RstWaitLast) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                unique case (rom_q.op)
                    OpCmd, OpData: begin
                        spi_data_d = rom_q.val;
                        lcd_dc_d   = (rom_q.op == OpData);
                        host_d     = 1'b0;
                        state_d    = StSend;
                    end
                    OpDelay: begin
                        if (rom_q.val == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            delay_d = rom_q.val;
                            tmr_clr = 1'b1;
                            state_d = StDelay;
                        end
                    end
                    OpEnd: begin
                        state_d = StReady;
                    end
                endcase
            end
            StSend: begin
                spi_send_o  = 1'b1;
                lcd_cs_n_o  = 1'b0;
                init_done_o = host_q;
                state_d     = StWait;
            end
            StWait: begin
                lcd_cs_n_o  = 1'b0;
                init_done_o = host_q;
                if (spi_done_i) begin
                    if (host_q) begin
                        state_d = StReady;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StDelay: begin
                if (ms_tick && ms_q == MsW'(delay_q) - MsW'(1)) begin
                    advance = 1'b1;
                end
            end
            StReady: begin
                busy_o       = 1'b0;
                init_done_o  = 1'b1;
                // A restart wins over a host byte offered in the same cycle.
                host_ready_o = !start_i;
                if (start_i) begin
                    state_d = StHwRst;
                    tmr_clr = 1'b1;
                    host_d  = 1'b0;
                end else if (host_valid_i) begin
                    spi_data_d = host_data_i;
                    lcd_dc_d   = host_dc_i;
                    host_d     = 1'b1;
                    state_d    = StSend;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Step to the next ROM entry; the last address never wraps, it ends the init instead.
        if (advance) begin
            if (addr_q == AddrLast) begin
                state_d = StReady;
            end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            div_q      <= '0;
            ms_q       <= '0;
            delay_q    <= '0;
            spi_data_q <= '0;
            lcd_dc_q   <= 1'b0;
            host_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            div_q      <= div_d;
            ms_q       <= ms_d;
            delay_q    <= delay_d;
            spi_data_q <= spi_data_d;
            lcd_dc_q   <= lcd_dc_d;
            host_q     <= host_d;
        end
    end

    assign spi_data_o = spi_data_q;
    assign lcd_dc_o   = lcd_dc_q;

endmodule

// File: tb/tb_ili9341_cmd_seq.sv
// Self-checking bench for ili9341_cmd_seq with a fixed-latency byte engine model.
module tb_ili9341_cmd_seq;

    localparam int unsigned ClksPerMs  = 4;
    localparam int unsigned RstPulseMs = 2;
    localparam int unsigned RstWaitMs  = 3;
    localparam int unsigned RomAw      = 6;
    localparam int unsigned EngLat     = 10;
    // start cycle + HWRST + HWWAIT + FETCH + DECODE, then SEND
    localparam int unsigned FirstLat   = 1 + (RstPulseMs + RstWaitMs) * ClksPerMs + 2;
    // SEND + WAIT until done, then FETCH, DECODE, next SEND (or READY after END)
    localparam int unsigned ByteLat    = EngLat + 3;
    localparam int unsigned InitLen    = 21;
    // Expected init program, {op, val}: 0 cmd, 1 data, 2 delay, 3 end.
    localparam logic [9:0] InitSeq [InitLen] = '{
        10'h001, 10'h205, 10'h011, 10'h278, 10'h03A, 10'h155, 10'h036, 10'h148,
        10'h02A, 10'h100, 10'h100, 10'h100, 10'h1EF, 10'h02B, 10'h100, 10'h100,
        10'h101, 10'h13F, 10'h200, 10'h029, 10'h300
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       host_valid;
    logic       host_dc;
    logic [7:0] host_data;
    logic       host_ready;
    logic       spi_send;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       lcd_cs_n;
    logic       lcd_dc;
    logic       lcd_rst_n;
    logic       init_done;
    logic       busy;

    ili9341_cmd_seq #(
        .CLKS_PER_MS  (ClksPerMs),
        .RST_PULSE_MS (RstPulseMs),
        .RST_WAIT_MS  (RstWaitMs),
        .ROM_AW       (RomAw)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .host_valid_i (host_valid),
        .host_dc_i    (host_dc),
        .host_data_i  (host_data),
        .host_ready_o (host_ready),
        .spi_send_o   (spi_send),
        .spi_data_o   (spi_data),
        .spi_done_i   (spi_done),
        .lcd_cs_n_o   (lcd_cs_n),
        .lcd_dc_o     (lcd_dc),
        .lcd_rst_n_o  (lcd_rst_n),
        .init_done_o  (init_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        int unsigned cyc;
    } sb_t;

    sb_t         exp_q[$];
    int unsigned exp_ready_cyc = 0;

    // Queue the whole init program with the absolute cycle each byte must be sent in.
    task automatic push_init(input int unsigned ref_cyc);
        int unsigned t    = ref_cyc;
        int unsigned pend = 0;
        bit          first = 1'b1;
        bit          ended = 1'b0;
        for (int i = 0; i < InitLen; i++) begin
            logic [9:0] ent;
            ent = InitSeq[i];
            if (!ended) begin
                case (ent[9:8])
                    2'd0, 2'd1: begin
                        t += first ? FirstLat : ByteLat + pend;
                        first = 1'b0;
                        pend  = 0;
                        exp_q.push_back('{dc: ent[8], data: ent[7:0], cyc: t});
                    end
                    // extra FETCH + DECODE of the delay entry, plus the wait itself
                    2'd2: pend += 2 + int'(ent[7:0]) * ClksPerMs;
                    default: begin
                        exp_ready_cyc = t + ByteLat;
                        ended = 1'b1;
                    end
                endcase
            end
        end
    endtask

    // Byte engine model: spi_done pulses EngLat cycles after spi_send.
    int unsigned eng_cnt   = 0;
    bit          stray_req = 1'b0;
    initial begin
        spi_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) spi_done = 1'b1;
            end
            if (stray_req) begin
                spi_done  = 1'b1;
                stray_req = 1'b0;
            end
            if (rst_n && spi_send) eng_cnt = EngLat;
        end
    end

    // Monitor: host handshakes feed the scoreboard, sends drain it, CS/data tracked per cycle.
    bit          in_flight = 1'b0;
    sb_t         cur;
    int unsigned hs_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_flight = 1'b0;
            check_eq("cs_n_in_reset", lcd_cs_n, 1'b1);
        end else begin
            if (host_valid && host_ready) begin
                hs_cnt++;
                exp_q.push_back('{dc: host_dc, data: host_data, cyc: cyc + 1});
            end
            if (spi_send) begin
                check_eq("send_overlap", in_flight, 1'b0);
                if (exp_q.size() == 0) begin
                    check_eq("send_expected", exp_q.size(), 1);
                    cur = '{dc: lcd_dc, data: spi_data, cyc: cyc};
                end else begin
                    cur = exp_q.pop_front();
                    check_eq("send_data", spi_data, cur.data);
                    check_eq("send_dc", lcd_dc, cur.dc);
                    check_eq("send_cycle", cyc, cur.cyc);
                end
                in_flight = 1'b1;
            end
            if (in_flight) begin
                check_eq("data_stable", spi_data, cur.data);
                check_eq("dc_stable", lcd_dc, cur.dc);
            end
            check_eq("cs_n", lcd_cs_n, !in_flight);
            if (in_flight && spi_done) in_flight = 1'b0;
        end
    end

    task automatic pulse_start(input bit with_host, input logic [7:0] hdata);
        @(posedge clk);
        #1;
        start      = 1'b1;
        host_valid = with_host;
        host_dc    = 1'b1;
        host_data  = hdata;
        push_init(cyc);
        #1;
        if (with_host) check_eq("host_ready_on_start", host_ready, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follows an init run from the cycle after start up to READY.
    task automatic check_init_run();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!lcd_rst_n && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_eq("rst_low_cycles", n, RstPulseMs * ClksPerMs);
        host_valid = 1'b0;
        n = 0;
        while (!spi_send && n < 1000) begin
            n++;
            @(negedge clk);
        end
        // HWWAIT plus FETCH and DECODE of the first entry
        check_eq("rst_high_cycles", n, RstWaitMs * ClksPerMs + 2);
        n = 0;
        while (!init_done && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check_eq("init_done_seen", init_done, 1'b1);
        check_eq("ready_cycle", cyc, exp_ready_cyc);
        check_eq("init_sb_drained", exp_q.size(), 0);
        check_eq("busy_in_ready", busy, 1'b0);
        check_eq("host_ready_in_ready", host_ready, 1'b1);
    endtask

    task automatic host_burst(input logic dc, input logic [7:0] data, input int unsigned count);
        int unsigned base = hs_cnt;
        int unsigned prev = 0;
        int unsigned n;
        @(posedge clk);
        #1;
        host_valid = 1'b1;
        host_dc    = dc;
        host_data  = data;
        for (int i = 0; i < count; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!host_ready && n < 200);
            check_eq("host_hs_seen", host_ready, 1'b1);
            if (i > 0) check_eq("host_hs_gap", cyc - prev, EngLat + 2);
            prev = cyc;
            if (i == count - 1) begin
                @(posedge clk);
                #1;
                host_valid = 1'b0;
            end else if (i == 0) begin
                @(negedge clk);
                check_eq("init_done_host_send", init_done, 1'b1);
                check_eq("busy_host_send", busy, 1'b1);
            end
        end
        n = 0;
        while (!(init_done && lcd_cs_n && exp_q.size() == 0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("host_sb_drained", exp_q.size(), 0);
        check_eq("host_hs_count", hs_cnt - base, count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned hs_before;
        rst_n      = 1'b0;
        start      = 1'b0;
        host_valid = 1'b0;
        host_dc    = 1'b0;
        host_data  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_spi_send", spi_send, 1'b0);
        check_eq("rst_spi_data", spi_data, 8'h00);
        check_eq("rst_cs_n", lcd_cs_n, 1'b1);
        check_eq("rst_dc", lcd_dc, 1'b0);
        check_eq("rst_lcd_rst_n", lcd_rst_n, 1'b0);
        check_eq("rst_host_ready", host_ready, 1'b0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_lcd_rst_n", lcd_rst_n, 1'b0);
        check_eq("idle_busy", busy, 1'b0);

        // Full init; host_valid offered during reset pulse must not be taken.
        hs_before = hs_cnt;
        pulse_start(1'b1, 8'hAA);
        check_init_run();
        check_eq("hs_outside_ready", hs_cnt, hs_before);

        // Host stream.
        host_burst(1'b1, 8'hF8, 3);
        host_burst(1'b0, RAMWR_BYTE(), 2);

        // Reset in the middle of the first byte, then re-init from address 0.
        pulse_start(1'b0, 8'h00);
        n = 0;
        while (!spi_send && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_eq("send_before_reset", spi_send, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_spi_send", spi_send, 1'b0);
        check_eq("midrst_spi_data", spi_data, 8'h00);
        check_eq("midrst_cs_n", lcd_cs_n, 1'b1);
        check_eq("midrst_dc", lcd_dc, 1'b0);
        check_eq("midrst_lcd_rst_n", lcd_rst_n, 1'b0);
        check_eq("midrst_init_done", init_done, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_start(1'b0, 8'h00);
        check_init_run();

        // Stray spi_done in READY changes nothing.
        @(negedge clk);
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("stray_init_done", init_done, 1'b1);
        check_eq("stray_busy", busy, 1'b0);
        check_eq("stray_host_ready", host_ready, 1'b1);
        check_eq("stray_cs_n", lcd_cs_n, 1'b1);
        check_eq("stray_no_send", exp_q.size(), 0);

        // start beats a simultaneous host byte.
        hs_before = hs_cnt;
        pulse_start(1'b1, 8'h77);
        check_init_run();
        check_eq("hs_on_start", hs_cnt, hs_before);
        host_burst(1'b1, 8'h3C, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic logic [7:0] RAMWR_BYTE();
        return 8'h2C;
    endfunction

endmodule
